// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared state encoding, lamp patterns and brake masks for the tail-light sequencer
package tail_light_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        L1      = 4'd1,
        L2      = 4'd2,
        L3      = 4'd3,
        R1      = 4'd4,
        R2      = 4'd5,
        R3      = 4'd6,
        HAZ_ON  = 4'd7,
        HAZ_OFF = 4'd8
    } state_t;

    // Lamp vectors are ordered {lc, lb, la, ra, rb, rc}
    localparam logic [5:0] PAT_OFF   = 6'b000000;
    localparam logic [5:0] PAT_ALL   = 6'b111111;
    localparam logic [5:0] PAT_L1    = 6'b001000;
    localparam logic [5:0] PAT_L2    = 6'b011000;
    localparam logic [5:0] PAT_L3    = 6'b111000;
    localparam logic [5:0] PAT_R1    = 6'b000100;
    localparam logic [5:0] PAT_R2    = 6'b000110;
    localparam logic [5:0] PAT_R3    = 6'b000111;
    localparam logic [5:0] BRK_LEFT  = 6'b111000;
    localparam logic [5:0] BRK_RIGHT = 6'b000111;

    // Animation pattern of a state with the brake overlay applied to the idle side
    function automatic logic [5:0] lamp_pattern(input state_t s, input logic brk);
        logic [5:0] p;
        case (s)
            L1:      p = PAT_L1 | (brk ? BRK_RIGHT : PAT_OFF);
            L2:      p = PAT_L2 | (brk ? BRK_RIGHT : PAT_OFF);
            L3:      p = PAT_L3 | (brk ? BRK_RIGHT : PAT_OFF);
            R1:      p = PAT_R1 | (brk ? BRK_LEFT : PAT_OFF);
            R2:      p = PAT_R2 | (brk ? BRK_LEFT : PAT_OFF);
            R3:      p = PAT_R3 | (brk ? BRK_LEFT : PAT_OFF);
            HAZ_ON:  p = PAT_ALL;
            HAZ_OFF: p = PAT_OFF;
            default: p = brk ? PAT_ALL : PAT_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tail_light_tick_prescaler.sv
// tick_prescaler: free-running step counter that pulses tick once every TICK_DIV cycles unless cleared
module tick_prescaler #(
    parameter int TICK_DIV = 4,
    localparam int CNT_W = $clog2(TICK_DIV > 1 ? TICK_DIV : 2)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = (count_q == CNT_W'(TICK_DIV - 1));

    // Restart from zero when cleared, otherwise count up and wrap on tick
    always_comb begin
        count_d = clear ? '0 : (tick ? '0 : count_q + CNT_W'(1));
    end

    // Counter register, asynchronously cleared by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/tail_light_sequencer.sv
// tail_light_sequencer: arbitrates turn/hazard/brake requests and sequences the six tail lamps
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    input  logic brake,
    output logic lc,
    output logic lb,
    output logic la,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] lamps_q;
    logic [5:0] lamps_d;
    logic       busy_q;
    logic       busy_d;
    logic       hz;
    logic       tick;
    logic       clear;

    // Both turn signals together behave as a hazard request
    assign hz = hazard | (left & right);

    // Every state starts its dwell with a fresh count; IDLE keeps the counter parked
    assign clear = (state_q == IDLE) || (state_d != state_q);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // Next-state: IDLE reacts immediately, all other states advance only on tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = hz ? HAZ_ON : (left ? L1 : (right ? R1 : IDLE));
            L1:      state_d = tick ? (hz ? HAZ_ON : L2) : L1;
            L2:      state_d = tick ? (hz ? HAZ_ON : L3) : L2;
            L3:      state_d = tick ? (hz ? HAZ_ON : IDLE) : L3;
            R1:      state_d = tick ? (hz ? HAZ_ON : R2) : R1;
            R2:      state_d = tick ? (hz ? HAZ_ON : R3) : R2;
            R3:      state_d = tick ? (hz ? HAZ_ON : IDLE) : R3;
            HAZ_ON:  state_d = tick ? HAZ_OFF : HAZ_ON;
            HAZ_OFF: state_d = tick ? (hz ? HAZ_ON : IDLE) : HAZ_OFF;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they land on the same edge as the transition
    always_comb begin
        lamps_d = lamp_pattern(state_d, brake);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers, asynchronously reset to idle with all lamps dark
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lamps_q <= PAT_OFF;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lamps_q <= lamps_d;
            busy_q  <= busy_d;
        end
    end

    assign {lc, lb, la, ra, rb, rc} = lamps_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb_tail_light_sequencer: directed self-checking bench for the tail-light sequencer
module tb_tail_light_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic left = 1'b0;
    logic right = 1'b0;
    logic hazard = 1'b0;
    logic brake = 1'b0;
    logic lc, lb, la, ra, rb, rc, busy;
    logic lc1, lb1, la1, ra1, rb1, rc1, busy1;
    logic [5:0] lamps;
    logic [5:0] lamps1;
    int passed = 0;
    int total = 0;

    assign lamps  = {lc, lb, la, ra, rb, rc};
    assign lamps1 = {lc1, lb1, la1, ra1, rb1, rc1};

    always #5 clk = ~clk;

    tail_light_sequencer #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
        .lc(lc), .lb(lb), .la(la), .ra(ra), .rb(rb), .rc(rc), .busy(busy)
    );

    tail_light_sequencer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
        .lc(lc1), .lb(lb1), .la(la1), .ra(ra1), .rb(rb1), .rc(rc1), .busy(busy1)
    );

    task automatic do_reset();
        {left, right, hazard, brake} = 4'b0000;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {left, right, hazard, brake} = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b000000) $display("FAIL reset_lamps: got %b expected %b", lamps, 6'b000000);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected %b", busy, 1'b0);
        else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b111111) $display("FAIL reset_release_lamps: got %b expected %b", lamps, 6'b111111);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("FAIL reset_release_busy: got %b expected %b", busy, 1'b1);
        else passed++;
    endtask

    task automatic test_held_left();
        logic [5:0] e;
        logic eb;
        do_reset();
        left = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            e = (i <= 4) ? 6'b001000 : (i <= 8) ? 6'b011000 : (i <= 12) ? 6'b111000 :
                (i == 13) ? 6'b000000 : 6'b001000;
            eb = (i != 13);
            total++;
            if (lamps !== e) $display("FAIL held_left[%0d] lamps: got %b expected %b", i, lamps, e);
            else passed++;
            total++;
            if (busy !== eb) $display("FAIL held_left[%0d] busy: got %b expected %b", i, busy, eb);
            else passed++;
        end
    endtask

    task automatic test_right_pulse();
        logic [5:0] e;
        do_reset();
        right = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            right = 1'b0;
            e = (i <= 4) ? 6'b000100 : (i <= 8) ? 6'b000110 : (i <= 12) ? 6'b000111 : 6'b000000;
            total++;
            if (lamps !== e) $display("FAIL right_pulse[%0d] lamps: got %b expected %b", i, lamps, e);
            else passed++;
        end
        total++;
        if (busy !== 1'b0) $display("FAIL right_pulse_idle busy: got %b expected %b", busy, 1'b0);
        else passed++;
    endtask

    task automatic test_hazard_lr();
        logic [5:0] e;
        logic eb;
        do_reset();
        left = 1'b1;
        right = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 18) begin
                left = 1'b0;
                right = 1'b0;
            end
            e = (((i - 1) / 4) % 2 == 0 && i <= 20) ? 6'b111111 : 6'b000000;
            eb = (i <= 24);
            total++;
            if (lamps !== e) $display("FAIL hazard_lr[%0d] lamps: got %b expected %b", i, lamps, e);
            else passed++;
            total++;
            if (busy !== eb) $display("FAIL hazard_lr[%0d] busy: got %b expected %b", i, busy, eb);
            else passed++;
        end
    endtask

    task automatic test_brake();
        logic [5:0] e;
        do_reset();
        brake = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b111111) $display("FAIL brake_idle lamps: got %b expected %b", lamps, 6'b111111);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL brake_idle busy: got %b expected %b", busy, 1'b0);
        else passed++;
        brake = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b000000) $display("FAIL brake_release lamps: got %b expected %b", lamps, 6'b000000);
        else passed++;
        left = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        left = 1'b0;
        total++;
        if (lamps !== 6'b011000) $display("FAIL brake_l2_pre lamps: got %b expected %b", lamps, 6'b011000);
        else passed++;
        brake = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b011111) $display("FAIL brake_l2 lamps: got %b expected %b", lamps, 6'b011111);
        else passed++;
        brake = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b011000) $display("FAIL brake_l2_off lamps: got %b expected %b", lamps, 6'b011000);
        else passed++;
        do_reset();
        hazard = 1'b1;
        brake = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            e = (i <= 4) ? 6'b111111 : 6'b000000;
            total++;
            if (lamps !== e) $display("FAIL brake_hazard[%0d] lamps: got %b expected %b", i, lamps, e);
            else passed++;
        end
    endtask

    task automatic test_preempt();
        logic [5:0] e;
        do_reset();
        left = 1'b1;
        @(posedge clk);
        #1;
        left = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b011000) $display("FAIL preempt_l2 lamps: got %b expected %b", lamps, 6'b011000);
        else passed++;
        hazard = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            @(posedge clk);
            #1;
            e = (i <= 8) ? 6'b011000 : 6'b111111;
            total++;
            if (lamps !== e) $display("FAIL preempt[%0d] lamps: got %b expected %b", i, lamps, e);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        right = 1'b1;
        @(posedge clk);
        #1;
        right = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b000110) $display("FAIL async_r2 lamps: got %b expected %b", lamps, 6'b000110);
        else passed++;
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (lamps !== 6'b000000) $display("FAIL async_reset lamps: got %b expected %b", lamps, 6'b000000);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL async_reset busy: got %b expected %b", busy, 1'b0);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (lamps !== 6'b000000) $display("FAIL async_reset_hold lamps: got %b expected %b", lamps, 6'b000000);
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_tick_div1();
        logic [5:0] e;
        do_reset();
        left = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            e = (i == 1 || i == 5) ? 6'b001000 : (i == 2) ? 6'b011000 : (i == 3) ? 6'b111000 : 6'b000000;
            total++;
            if (lamps1 !== e) $display("FAIL tick_div1[%0d] lamps: got %b expected %b", i, lamps1, e);
            else passed++;
        end
        left = 1'b0;
    endtask

    initial begin
        test_reset();
        test_held_left();
        test_right_pulse();
        test_hazard_lr();
        test_brake();
        test_preempt();
        test_async_reset();
        test_tick_div1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
